// File: rtl/mem_req_ctrl.sv
// Memory-stage request sequencer for a single SRAM-like data port.
// It bounds the number of transactions in flight, returns answers in order, and absorbs answers that were flushed.
module mem_req_ctrl #(
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned CNT_W           = 3
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        flush,
  input  logic        req_valid,
  input  logic        req_wr,
  input  logic [1:0]  req_size,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata,
  output logic        resp_valid,
  output logic        resp_wr,
  output logic [31:0] resp_rdata,
  output logic        busy,
  output logic        err,
  output logic [31:0] perfcnt_addr_wait,
  output logic [31:0] perfcnt_full_stall
);

  localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  logic [CNT_W-1:0]           out_cnt;
  logic [PTR_W-1:0]           rd_ptr;
  logic [PTR_W-1:0]           wr_ptr;
  logic [MAX_OUTSTANDING-1:0] wr_q;
  logic [MAX_OUTSTANDING-1:0] disc_q;

  logic full;
  logic accept;
  logic pop;
  logic head_wr;
  logic head_disc;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
  endfunction

  // full is derived from the registered count only, so a same-cycle pop never enables an issue
  always_comb begin
    full       = (out_cnt == CNT_W'(MAX_OUTSTANDING));
    data_req   = req_valid & ~full & ~flush;
    accept     = data_req & data_addr_ok;
    req_ready  = accept;
    pop        = data_data_ok & (out_cnt != '0);
    head_wr    = wr_q[rd_ptr];
    head_disc  = disc_q[rd_ptr];
    resp_valid = pop & ~head_disc;
    resp_wr    = resp_valid & head_wr;
    busy       = (out_cnt != '0);
  end

  assign data_wr    = req_wr;
  assign data_size  = req_size;
  assign data_addr  = req_addr;
  assign data_wdata = req_wdata;
  assign resp_rdata = data_rdata;

  // Flush marks every slot; a slot that is pushed later has its discard bit cleared again
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      out_cnt <= '0;
      wr_q    <= '0;
      disc_q  <= '0;
    end else begin
      if (flush) begin
        disc_q <= '1;
      end
      if (accept) begin
        wr_q[wr_ptr]   <= req_wr;
        disc_q[wr_ptr] <= 1'b0;
        wr_ptr         <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({accept, pop})
        2'b10:   out_cnt <= out_cnt + 1'b1;
        2'b01:   out_cnt <= out_cnt - 1'b1;
        default: out_cnt <= out_cnt;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      err <= 1'b0;
    end else if (data_data_ok && (out_cnt == '0)) begin
      err <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      perfcnt_addr_wait  <= '0;
      perfcnt_full_stall <= '0;
    end else begin
      if (data_req && !data_addr_ok) begin
        perfcnt_addr_wait <= perfcnt_addr_wait + 32'd1;
      end
      if (req_valid && full) begin
        perfcnt_full_stall <= perfcnt_full_stall + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_mem_req_ctrl.sv
// Directed bench for mem_req_ctrl: inputs are driven on the falling edge and outputs checked 1 ns later.
module tb_mem_req_ctrl;

  logic        clk = 1'b0;
  logic        resetn;
  logic        flush;
  logic        req_valid;
  logic        req_wr;
  logic [1:0]  req_size;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_ready;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;
  logic        resp_valid;
  logic        resp_wr;
  logic [31:0] resp_rdata;
  logic        busy;
  logic        err;
  logic [31:0] perfcnt_addr_wait;
  logic [31:0] perfcnt_full_stall;

  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;

  mem_req_ctrl #(.MAX_OUTSTANDING(2), .CNT_W(3)) dut (
    .clk(clk), .resetn(resetn), .flush(flush),
    .req_valid(req_valid), .req_wr(req_wr), .req_size(req_size),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .resp_valid(resp_valid), .resp_wr(resp_wr), .resp_rdata(resp_rdata),
    .busy(busy), .err(err),
    .perfcnt_addr_wait(perfcnt_addr_wait), .perfcnt_full_stall(perfcnt_full_stall)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "simulation did not finish");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Apply one cycle's inputs on the falling edge, then let combinational outputs settle
  task automatic cyc(input logic v, input logic wr, input logic [31:0] addr,
                     input logic aok, input logic dok, input logic [31:0] rdata, input logic fl);
    @(negedge clk);
    req_valid    = v;
    req_wr       = wr;
    req_addr     = addr;
    data_addr_ok = aok;
    data_data_ok = dok;
    data_rdata   = rdata;
    flush        = fl;
    #1;
  endtask

  initial begin
    resetn = 1'b0; flush = 1'b0; req_valid = 1'b0; req_wr = 1'b0; req_size = 2'd2;
    req_addr = '0; req_wdata = 32'hA5A5_0F0F; data_addr_ok = 1'b0; data_data_ok = 1'b0;
    data_rdata = '0;
    #23;
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_data_req", data_req, 0);
    chk("rst_addr_wait", perfcnt_addr_wait, 0);
    chk("rst_full_stall", perfcnt_full_stall, 0);
    @(negedge clk);
    resetn = 1'b1;

    // single load
    cyc(1, 0, 32'h8000_0004, 1, 0, 0, 0);
    chk("t1_data_req", data_req, 1);
    chk("t1_req_ready", req_ready, 1);
    chk("t1_data_addr", data_addr, 32'h8000_0004);
    chk("t1_data_wdata", data_wdata, 32'hA5A5_0F0F);
    chk("t1_busy_c0", busy, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("t1_busy_c1", busy, 1);
    chk("t1_resp_c1", resp_valid, 0);
    cyc(0, 0, 0, 0, 1, 32'hDEAD_BEEF, 0);
    chk("t1_resp_valid", resp_valid, 1);
    chk("t1_resp_wr", resp_wr, 0);
    chk("t1_resp_rdata", resp_rdata, 32'hDEAD_BEEF);
    chk("t1_busy_c2", busy, 1);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("t1_busy_c3", busy, 0);

    // back-to-back: store, load, load with two slots
    cyc(1, 1, 32'h0000_00A0, 1, 0, 0, 0);
    chk("t2_ready0", req_ready, 1);
    chk("t2_data_wr0", data_wr, 1);
    cyc(1, 0, 32'h0000_00A1, 1, 0, 0, 0);
    chk("t2_ready1", req_ready, 1);
    cyc(1, 0, 32'h0000_00A2, 1, 0, 0, 0);
    chk("t2_gate_c2", data_req, 0);
    chk("t2_ready_c2", req_ready, 0);
    cyc(1, 0, 32'h0000_00A2, 1, 1, 32'h1111_1111, 0);
    chk("t2_gate_c3", data_req, 0);
    chk("t2_resp0_valid", resp_valid, 1);
    chk("t2_resp0_wr", resp_wr, 1);
    cyc(1, 0, 32'h0000_00A2, 1, 1, 32'h2222_2222, 0);
    chk("t2_full_stall", perfcnt_full_stall, 2);
    chk("t2_ready_c4", req_ready, 1);
    chk("t2_addr_c4", data_addr, 32'h0000_00A2);
    chk("t2_resp1_valid", resp_valid, 1);
    chk("t2_resp1_wr", resp_wr, 0);
    cyc(0, 0, 0, 0, 1, 32'h3333_3333, 0);
    chk("t2_resp2_valid", resp_valid, 1);
    chk("t2_resp2_wr", resp_wr, 0);
    chk("t2_resp2_rdata", resp_rdata, 32'h3333_3333);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("t2_busy_end", busy, 0);

    // address stall for five cycles
    for (int i = 0; i < 5; i++) begin
      cyc(1, 0, 32'h0000_0100, 0, 0, 0, 0);
      chk("t3_ready_wait", req_ready, 0);
      chk("t3_data_req_wait", data_req, 1);
    end
    cyc(1, 0, 32'h0000_0100, 1, 0, 0, 0);
    chk("t3_ready_c5", req_ready, 1);
    chk("t3_addr_wait", perfcnt_addr_wait, 5);
    cyc(0, 0, 0, 0, 1, 32'h1234_5678, 0);
    chk("t3_resp_valid", resp_valid, 1);
    chk("t3_resp_rdata", resp_rdata, 32'h1234_5678);

    // flush with two in flight: both answers absorbed
    cyc(1, 0, 32'h0000_0200, 1, 0, 0, 0);
    cyc(1, 1, 32'h0000_0204, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 1);
    chk("t4_busy_flush", busy, 1);
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 32'h4444_4444, 0);
    chk("t4_drop0", resp_valid, 0);
    chk("t4_busy_c3", busy, 1);
    cyc(0, 0, 0, 0, 1, 32'h5555_5555, 0);
    chk("t4_drop1", resp_valid, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("t4_busy_c5", busy, 0);
    chk("t4_err", err, 0);

    // completion in the flush cycle is delivered; flush blocks issue
    cyc(1, 1, 32'h0000_0300, 1, 0, 0, 0);
    cyc(1, 0, 32'h0000_0304, 1, 1, 32'h6666_6666, 1);
    chk("t5_flush_resp", resp_valid, 1);
    chk("t5_flush_resp_wr", resp_wr, 1);
    chk("t5_flush_data_req", data_req, 0);
    chk("t5_flush_ready", req_ready, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("t5_busy", busy, 0);
    // a request after flush must not inherit the discard mark
    cyc(1, 0, 32'h0000_0308, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 32'h7777_7777, 0);
    chk("t5_post_flush_resp", resp_valid, 1);

    // spurious completion
    cyc(0, 0, 0, 0, 1, 32'h8888_8888, 0);
    chk("t6_spur_resp", resp_valid, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("t6_err_set", err, 1);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("t6_err_sticky", err, 1);

    // async reset between clock edges with one outstanding
    cyc(1, 0, 32'h0000_0400, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("t7_busy_pre", busy, 1);
    resetn = 1'b0;
    #1;
    chk("t7_busy_async", busy, 0);
    chk("t7_err_async", err, 0);
    chk("t7_addr_wait_async", perfcnt_addr_wait, 0);
    chk("t7_full_stall_async", perfcnt_full_stall, 0);
    @(negedge clk);
    resetn = 1'b1;
    cyc(0, 0, 0, 0, 1, 32'h9999_9999, 0);
    chk("t7_late_resp", resp_valid, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("t7_late_err", err, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
